// File: rtl/game_pkg.sv
// Shared types and constants for the game clock speed-select logic.
package game_pkg;

   // Rate code consumed by the clock divider: 2'b00 is ratio 1, 2'b11 is ratio 8.
   typedef logic [1:0] rate_t;

   localparam rate_t RATE_FASTEST = 2'b00;
   localparam rate_t RATE_SLOWEST = 2'b11;
   localparam rate_t RATE_DEFAULT = 2'b10;
   localparam int    CLK_HZ       = 50_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Per-button front end: 2-FF synchroniser, debounce counter and rising-edge
// step request. With GAME_SPEED_AUTO_REPEAT_EN defined, a held button also
// issues a repeat step every REPEAT_CYCLES cycles.
module btn_debounce
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject configurations the debounce and repeat counters cannot represent.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
   end

   logic             meta;
   logic             sync;
   logic             stable;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;
   logic             press;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so each flop samples its pre-edge input;
      // blocking here would collapse the two synchroniser stages into one.
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

   // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Delayed copy of the debounced level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) stable_d <= 1'b0;
      else     stable_d <= stable;
   end

   assign press = stable & ~stable_d;

`ifdef GAME_SPEED_AUTO_REPEAT_EN
   localparam int              RPT_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_fire;

   // Repeat timer restarts at the press pulse and clears while released.
   always_ff @(posedge clk) begin
      if (rst || !stable || press) rpt_cnt <= '0;
      else if (rpt_cnt == RPT_LAST) rpt_cnt <= '0;
      else                          rpt_cnt <= rpt_cnt + 1'b1;
   end

   assign rpt_fire = stable & ~press & (rpt_cnt == RPT_LAST);
   assign step     = press | rpt_fire;
`else
   assign step = press;
`endif

endmodule

// File: rtl/game_speed_ctrl.sv
// Speed-select stage for the game clock divider: two debounced buttons step a
// saturating 2-bit rate code (2'b00 fastest, 2'b11 slowest).
// Optional auto-repeat is enabled by defining GAME_SPEED_AUTO_REPEAT_EN.
module game_speed_ctrl
   import game_pkg::*;
#(
   parameter int    DEBOUNCE_CYCLES = 1_000_000,
   parameter rate_t RESET_RATE      = RATE_DEFAULT,
   parameter int    REPEAT_CYCLES   = 25_000_000
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  btn_faster,
   input  logic  btn_slower,
   output rate_t clk_rate,
   output logic  rate_changed
);

   logic step_faster;
   logic step_slower;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_faster (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_faster),
      .step (step_faster)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_slower (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_slower),
      .step (step_slower)
   );

   // Apply one saturating step per accepted request; simultaneous requests cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_rate     <= RESET_RATE;
         rate_changed <= 1'b0;
      end else begin
         rate_changed <= 1'b0;
         if (step_faster && !step_slower && clk_rate != RATE_FASTEST) begin
            clk_rate     <= clk_rate - 2'd1;
            rate_changed <= 1'b1;
         end else if (step_slower && !step_faster && clk_rate != RATE_SLOWEST) begin
            clk_rate     <= clk_rate + 2'd1;
            rate_changed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Self-checking bench for game_speed_ctrl (default build, auto-repeat off).
// A reference model predicts each rate step; a monitor checks DUT pulses
// against the expected-step queue and the rate code every cycle.
module tb_game_speed_ctrl;
   import game_pkg::*;

   localparam int DEB = 4;
   localparam int RPT = 8;

   logic  clk = 1'b0;
   logic  rst;
   logic  btn_faster;
   logic  btn_slower;
   rate_t clk_rate;
   logic  rate_changed;

   game_speed_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .RESET_RATE      (RATE_DEFAULT),
      .REPEAT_CYCLES   (RPT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_faster   (btn_faster),
      .btn_slower   (btn_slower),
      .clk_rate     (clk_rate),
      .rate_changed (rate_changed)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int cyc;
      int rate;
   } exp_t;

   exp_t sb[$];
   exp_t head;

   int           cyc    = 0;
   int           m_rate = 2;
   bit           m_rst  = 1'b1;
   logic [DEB:0] hf = '0;   // raw faster samples, bit 0 newest
   logic [DEB:0] hs = '0;
   bit           st_f = 1'b0, st_s = 1'b0;
   bit           pf = 1'b0, ps = 1'b0;

   // A debounced level flips when the last DEB synchronised samples (raw
   // samples delayed by two cycles: history bits DEB..1) all disagree with it.
   function automatic bit flips(input logic [DEB:0] h, input bit st);
      return st ? (h[DEB:1] == '0) : (&h[DEB:1]);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_rst  = 1'b1;
         m_rate = 2;
         hf = '0; hs = '0;
         st_f = 1'b0; st_s = 1'b0;
         pf = 1'b0; ps = 1'b0;
      end else begin
         m_rst = 1'b0;
         if (pf && !ps && m_rate != 0) begin
            m_rate = m_rate - 1;
            sb.push_back('{cyc, m_rate});
         end else if (ps && !pf && m_rate != 3) begin
            m_rate = m_rate + 1;
            sb.push_back('{cyc, m_rate});
         end
         pf = 1'b0; ps = 1'b0;
         if (flips(hf, st_f)) begin st_f = !st_f; pf = st_f; end
         if (flips(hs, st_s)) begin st_s = !st_s; ps = st_s; end
         hf = {hf[DEB-1:0], btn_faster};
         hs = {hs[DEB-1:0], btn_slower};
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!m_rst) begin
         check("clk_rate", 32'(clk_rate), m_rate);
         if (rate_changed) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: rate_changed=1 at cycle %0d, expected no step", cyc);
            end else begin
               head = sb.pop_front();
               check("pulse_cycle", cyc, head.cyc);
               check("pulse_rate", 32'(clk_rate), head.rate);
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_pulse: rate_changed=0 at cycle %0d, expected step to %0d at cycle %0d",
                     cyc, sb[0].rate, sb[0].cyc);
            head = sb.pop_front();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold(input bit f, input bit s, input int n);
      btn_faster = f;
      btn_slower = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit f, input bit s);
      hold(f, s, 10);
      hold(1'b0, 1'b0, 10);
   endtask

   initial begin
      rst        = 1'b1;
      btn_faster = 1'b0;
      btn_slower = 1'b0;

      // Reset and idle
      hold(1'b0, 1'b0, 2);
      rst = 1'b0;
      check("reset_rate", 32'(clk_rate), 32'd2);
      check("reset_pulse", 32'(rate_changed), 32'd0);
      hold(1'b0, 1'b0, 20);
      check("idle_rate", 32'(clk_rate), 32'd2);

      // Bouncing slower button never settles
      repeat (5) begin
         hold(1'b0, 1'b1, 2);
         hold(1'b0, 1'b0, 1);
      end
      hold(1'b0, 1'b0, 10);
      check("bounce_rate", 32'(clk_rate), 32'd2);

      // Held faster button: exactly one step
      hold(1'b1, 1'b0, 15);
      check("held_rate", 32'(clk_rate), 32'd1);
      hold(1'b0, 1'b0, 10);

      // Saturation at both ends
      press(1'b1, 1'b0);
      check("to_fastest", 32'(clk_rate), 32'd0);
      press(1'b1, 1'b0);
      check("sat_fastest", 32'(clk_rate), 32'd0);
      repeat (3) press(1'b0, 1'b1);
      check("to_slowest", 32'(clk_rate), 32'd3);
      press(1'b0, 1'b1);
      check("sat_slowest", 32'(clk_rate), 32'd3);

      // Simultaneous presses cancel; staggered by one cycle they both apply
      press(1'b1, 1'b1);
      check("simul_rate", 32'(clk_rate), 32'd3);
      hold(1'b1, 1'b0, 1);
      press(1'b1, 1'b1);
      check("stagger_rate", 32'(clk_rate), 32'd3);

      // Reset mid-debounce with faster held through reset
      press(1'b0, 1'b0);
      hold(1'b1, 1'b0, 3);
      rst = 1'b1;
      hold(1'b1, 1'b0, 1);
      rst = 1'b0;
      check("midrst_rate", 32'(clk_rate), 32'd2);
      hold(1'b1, 1'b0, 12);
      check("midrst_step", 32'(clk_rate), 32'd1);
      hold(1'b0, 1'b0, 10);

      // Randomised button activity with occasional resets
      repeat (150) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            hold(1'(($urandom() >> 3) & 1), 1'(($urandom() >> 5) & 1), 1);
            rst = 1'b0;
         end
         hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 9));
      end
      hold(1'b0, 1'b0, 15);

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/game_speed_ctrl.md
Name: game_speed_ctrl

Overview:
Upstream speed-select stage for the game clock divider. It takes two raw push-buttons ("faster"/"slower") and synchronises and debounces each one. It then steps a saturating 2-bit rate code and drives the divider's clk_rate input. Encoding is fixed: 2'b00 is fastest (ratio 1) and 2'b11 is slowest (ratio 8).

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
RESET_RATE, 2'b10, clk_rate value after reset.
REPEAT_CYCLES, 25_000_000, auto-repeat interval in clk cycles; used only when AUTO_REPEAT_EN is defined.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  synchronous, active-high reset.
btn_faster  input  1  raw asynchronous button, high = pressed.
btn_slower  input  1  raw asynchronous button, high = pressed.
clk_rate  output  2  rate code consumed by the clock divider.
rate_changed  output  1  one-cycle pulse coincident with any clk_rate update.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state is updated only on posedge clk.
- Reset values: clk_rate = RESET_RATE, rate_changed = 0. Synchronisers, debounced levels, their delayed copies and all counters = 0.
- Per button, the pipeline is as follows:
  - 2-FF synchroniser produces sync.
  - Debounce: each edge where sync != stable, cnt increments. When cnt == DEBOUNCE_CYCLES-1 on such an edge, stable <= sync and cnt <= 0.
  - Any edge where sync == stable clears cnt to 0, so bounces restart the count.
  - Press pulse = stable & ~stable_d (combinational, from a registered delay).
- Latency: a raw input held high from edge 1 gives stable = 1 at edge DEBOUNCE_CYCLES+2. clk_rate and rate_changed update at edge DEBOUNCE_CYCLES+3.
- Step rules (evaluated on the edge where a press pulse is high):
  - faster only: if clk_rate != 2'b00, clk_rate <= clk_rate-1 and rate_changed <= 1. Otherwise no change and rate_changed stays 0.
  - slower only: if clk_rate != 2'b11, clk_rate <= clk_rate+1 and rate_changed <= 1. Otherwise saturate, no pulse.
  - Both pulses in the same cycle: ignored, no change, no pulse.
- A held button yields exactly one step; release must be debounced before the next press registers.
- No wrap-around; arithmetic is 2-bit with explicit saturation checks.
- rst mid-debounce discards the partial count. A button held through reset registers as a fresh press DEBOUNCE_CYCLES+3 edges after rst deasserts, because stable resets to 0.
- rate_changed is high for exactly one cycle per accepted step.

Optional Feature:
Macro: GAME_SPEED_AUTO_REPEAT_EN.
- Defined: while a debounced level stays high, a per-button repeat counter runs from the press pulse. Every REPEAT_CYCLES cycles it issues an additional step, using the same saturation and simultaneity rules. The counter clears on release or rst.
- Undefined: no repeat logic; the REPEAT_CYCLES parameter is ignored; exactly one step per press.

Decomposition:
- Shared package game_pkg:
  - Constants RATE_FASTEST = 2'b00, RATE_SLOWEST = 2'b11, RATE_DEFAULT = 2'b10, CLK_HZ = 50_000_000.
  - typedef rate_t, a 2-bit logic type.
- One sub-module, btn_debounce. It contains the synchroniser, debounce counter and rising-edge pulse, plus the repeat counter under the macro. It is instantiated once per button. The top level holds only the step/saturation logic and the output registers.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
1. Reset: rst high for 2 cycles -> clk_rate = 2'b10 and rate_changed = 0 afterwards; buttons low for 20 cycles -> no change.
2. btn_faster high from edge 1 for 15 cycles -> clk_rate 10 -> 01 at edge 7, rate_changed high for edge 7 only, no further change while held. With macro: a further step to 00 at edge 15.
3. Saturation: from 2'b00, a faster press -> stays 00 with no rate_changed. From 2'b11, a slower press -> stays 11 with no pulse.
4. Bounce: btn_slower pattern high 2 / low 1, repeated for 15 cycles, then low -> clk_rate and rate_changed unchanged.
5. Simultaneous: both buttons rise on the same edge and are held 10 cycles -> no change. Faster rises one cycle before slower -> 10 -> 01 at edge 7, then 01 -> 10 at edge 8, with two rate_changed pulses.
6. Reset mid-debounce: btn_faster held, rst pulsed at edge 4 -> clk_rate = 10 after reset, then 10 -> 01 exactly 7 edges after rst deasserts.
